// File: rtl/parking_pkg.sv
// parking_pkg -- shared definitions for the parking gate controller.
//   lane_state_e        : per-lane barrier state (IDLE / OPEN / WAIT_CLR)
//   LANE_*              : lane indices used for every per-lane vector
//   DEF_*_CYCLES        : default timing parameters
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN     = 2'd1,
    ST_WAIT_CLR = 2'd2
  } lane_state_e;

  localparam int unsigned LANE_ENTRY = 0;
  localparam int unsigned LANE_EXIT0 = 1;
  localparam int unsigned LANE_EXIT1 = 2;
  localparam int unsigned NUM_LANES  = 3;

  localparam int unsigned DEF_TIMEOUT_CYCLES  = 16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/gate_lane_fsm.sv
// gate_lane_fsm -- barrier state machine for one lane.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_req      : car present at the loop sensor (level)
//   i_pass     : car cleared the barrier (level)
//   i_allow    : lane may open (entry: not full, exit: floor holds cars)
//   i_pend     : this lane still has an undelivered event
//   o_state    : current lane state
//   o_ev       : one-cycle strobe, a pass was accepted while OPEN
module gate_lane_fsm
  import parking_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_pass,
  input  logic        i_allow,
  input  logic        i_pend,
  output lane_state_e o_state,
  output logic        o_ev
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  lane_state_e   r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req && i_allow) begin
            r_state <= ST_OPEN;
            r_cnt   <= '0;
          end
        end
        ST_OPEN: begin
          // A pass in the last open cycle still counts as a car.
          if (i_pass || (r_cnt == CNT_LAST)) begin
            r_state <= ST_WAIT_CLR;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT_CLR: begin
          // Holding here until the sensors clear and the event is sent
          // keeps one car from ever producing a second event.
          if (!i_req && !i_pass && !i_pend) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_ev    = (r_state == ST_OPEN) && i_pass;

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl -- three-lane parking barrier controller.
// Optional feature macro: PARKING_GATE_DEBOUNCE_EN (debounce all req/pass
// inputs by DEBOUNCE_CYCLES stable samples).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   entry_req/exit0_req/exit1_req     : car at lane loop sensor
//   entry_pass/exit0_pass/exit1_pass  : car cleared lane barrier
//   full, floor0_free, floor1_free    : occupancy status
//   car_in, car_out0, car_out1        : one-cycle events to occupancy manager
//   entry_open/exit0_open/exit1_open  : barrier-raise commands
//   entry_denied                      : car waiting at entry while full
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_req,
  input  logic exit0_req,
  input  logic exit1_req,
  input  logic entry_pass,
  input  logic exit0_pass,
  input  logic exit1_pass,
  input  logic full,
  input  logic floor0_free,
  input  logic floor1_free,
  output logic car_in,
  output logic car_out0,
  output logic car_out1,
  output logic entry_open,
  output logic exit0_open,
  output logic exit1_open,
  output logic entry_denied
);

  if (TIMEOUT_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("parking_gate_ctrl: TIMEOUT_CYCLES must be >= 2, DEBOUNCE_CYCLES >= 1");
  end

  // Sensor vector: [2:0] req, [5:3] pass, each indexed by lane.
  logic [5:0] w_raw;
  logic [5:0] w_flt;

  assign w_raw = {exit1_pass, exit0_pass, entry_pass,
                  exit1_req,  exit0_req,  entry_req};

`ifdef PARKING_GATE_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [5:0][DW-1:0] r_db_cnt;
  logic [5:0]         r_db_flt;

  for (genvar d = 0; d < 6; d++) begin : g_db
    // Count consecutive samples that disagree with the accepted value;
    // any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_db_cnt[d] <= '0;
        r_db_flt[d] <= 1'b0;
      end else if (w_raw[d] == r_db_flt[d]) begin
        r_db_cnt[d] <= '0;
      end else if (r_db_cnt[d] == DB_LAST) begin
        r_db_flt[d] <= w_raw[d];
        r_db_cnt[d] <= '0;
      end else begin
        r_db_cnt[d] <= r_db_cnt[d] + DW'(1);
      end
    end
  end

  assign w_flt = r_db_flt;
`else
  assign w_flt = w_raw;
`endif

  logic [NUM_LANES-1:0] w_req;
  logic [NUM_LANES-1:0] w_pass;
  logic [NUM_LANES-1:0] w_allow;
  logic [NUM_LANES-1:0] w_ev;
  logic [NUM_LANES-1:0] w_grant;
  logic [NUM_LANES-1:0] r_pend;
  lane_state_e          w_state [NUM_LANES];

  assign w_req  = w_flt[2:0];
  assign w_pass = w_flt[5:3];

  // full is only consulted when leaving IDLE; a gate already open stays open.
  assign w_allow[LANE_ENTRY] = !full;
  assign w_allow[LANE_EXIT0] = !floor0_free;
  assign w_allow[LANE_EXIT1] = !floor1_free;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gate_lane_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_req  (w_req[g]),
      .i_pass (w_pass[g]),
      .i_allow(w_allow[g]),
      .i_pend (r_pend[g]),
      .o_state(w_state[g]),
      .o_ev   (w_ev[g])
    );
  end

  // Fixed priority: exit0 > exit1 > entry, one pulse per cycle.
  always_comb begin
    w_grant = '0;
    if (r_pend[LANE_EXIT0])      w_grant[LANE_EXIT0] = 1'b1;
    else if (r_pend[LANE_EXIT1]) w_grant[LANE_EXIT1] = 1'b1;
    else if (r_pend[LANE_ENTRY]) w_grant[LANE_ENTRY] = 1'b1;
  end

  // A lane cannot raise a new event while its flag is set (it is parked in
  // WAIT_CLR), so set and clear never collide on the same bit.
  always_ff @(posedge clk) begin
    if (rst) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_grant) | w_ev;
  end

  assign car_in   = w_grant[LANE_ENTRY];
  assign car_out0 = w_grant[LANE_EXIT0];
  assign car_out1 = w_grant[LANE_EXIT1];

  assign entry_open = (w_state[LANE_ENTRY] == ST_OPEN);
  assign exit0_open = (w_state[LANE_EXIT0] == ST_OPEN);
  assign exit1_open = (w_state[LANE_EXIT1] == ST_OPEN);

  assign entry_denied = !rst && (w_state[LANE_ENTRY] == ST_IDLE)
                        && w_req[LANE_ENTRY] && full;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic entry_req = 0, exit0_req = 0, exit1_req = 0;
  logic entry_pass = 0, exit0_pass = 0, exit1_pass = 0;
  logic full = 0, floor0_free = 0, floor1_free = 0;
  logic car_in, car_out0, car_out1;
  logic entry_open, exit0_open, exit1_open, entry_denied;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .exit0_req(exit0_req), .exit1_req(exit1_req),
    .entry_pass(entry_pass), .exit0_pass(exit0_pass), .exit1_pass(exit1_pass),
    .full(full), .floor0_free(floor0_free), .floor1_free(floor1_free),
    .car_in(car_in), .car_out0(car_out0), .car_out1(car_out1),
    .entry_open(entry_open), .exit0_open(exit0_open), .exit1_open(exit1_open),
    .entry_denied(entry_denied)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {car_in, car_out0, car_out1, entry_open, exit0_open, exit1_open, entry_denied};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_open, c_ev, c_den;

    // Reset
    step(); step();
    chk("reset_outs", 32'(outs()), 32'd0);
    rst = 0;

    // Basic entry: open cycles 1..3, car_in at cycle 4
    entry_req = 1;
    #1 chk("ent_c0_open", 32'(entry_open), 32'd0);
    step(); chk("ent_c1_open", 32'(entry_open), 32'd1);
    step(); chk("ent_c2_open", 32'(entry_open), 32'd1);
    step(); chk("ent_c3_open", 32'(entry_open), 32'd1);
    chk("ent_c3_carin", 32'(car_in), 32'd0);
    entry_pass = 1;
    step();
    chk("ent_c4_open", 32'(entry_open), 32'd0);
    chk("ent_c4_carin", 32'(car_in), 32'd1);
    entry_req = 0; entry_pass = 0;
    step(); chk("ent_c5_carin", 32'(car_in), 32'd0);
    step();

    // Full: denied, never opens
    full = 1; entry_req = 1;
    #1 chk("full_denied_now", 32'(entry_denied), 32'd1);
    c_open = 0; c_ev = 0; c_den = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      c_open += int'(entry_open); c_ev += int'(car_in); c_den += int'(entry_denied);
    end
    chk("full_denied_cnt", 32'(c_den), 32'd20);
    chk("full_open_cnt", 32'(c_open), 32'd0);
    chk("full_carin_cnt", 32'(c_ev), 32'd0);
    entry_req = 0; full = 0;
    #1 chk("full_denied_drop", 32'(entry_denied), 32'd0);
    step();

    // Exit0 timeout: 16 open cycles, no event, held in WAIT_CLR by req
    exit0_req = 1;
    c_open = 0; c_ev = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      c_open += int'(exit0_open); c_ev += int'(car_out0);
      if (i == 16) chk("to_open_c16", 32'(exit0_open), 32'd1);
      if (i == 17) chk("to_open_c17", 32'(exit0_open), 32'd0);
    end
    chk("to_open_cnt", 32'(c_open), 32'd16);
    chk("to_ev_cnt", 32'(c_ev), 32'd0);
    exit0_req = 0;
    step();
    exit0_req = 1;
    step(); chk("to_reopen", 32'(exit0_open), 32'd1);
    exit0_pass = 1;
    step(); chk("to_pass_ev", 32'(car_out0), 32'd1);
    exit0_req = 0; exit0_pass = 0;
    step(); step();

    // Exit0 blocked when floor0 is empty
    floor0_free = 1; exit0_req = 1;
    step(); step();
    chk("empty_floor_open", 32'(exit0_open), 32'd0);
    exit0_req = 0; floor0_free = 0;
    step();

    // Simultaneous passes on all lanes: exit0, exit1, entry order
    entry_req = 1; exit0_req = 1; exit1_req = 1;
    step();
    chk("tri_open", 32'({entry_open, exit0_open, exit1_open}), 32'b111);
    entry_pass = 1; exit0_pass = 1; exit1_pass = 1;
    step();
    chk("tri_ev1", 32'({car_out0, car_out1, car_in}), 32'b100);
    chk("tri_closed", 32'({entry_open, exit0_open, exit1_open}), 32'b000);
    entry_req = 0; exit0_req = 0; exit1_req = 0;
    entry_pass = 0; exit0_pass = 0; exit1_pass = 0;
    step(); chk("tri_ev2", 32'({car_out0, car_out1, car_in}), 32'b010);
    step(); chk("tri_ev3", 32'({car_out0, car_out1, car_in}), 32'b001);
    step(); chk("tri_ev4", 32'({car_out0, car_out1, car_in}), 32'b000);
    step();

    // Held pass: one car_in only
    entry_req = 1;
    step();
    entry_pass = 1;
    c_ev = 0;
    for (int i = 0; i < 10; i++) begin
      step(); c_ev += int'(car_in);
    end
    chk("hold_open", 32'(entry_open), 32'd0);
    entry_req = 0; entry_pass = 0;
    for (int i = 0; i < 3; i++) begin
      step(); c_ev += int'(car_in);
    end
    chk("hold_carin_cnt", 32'(c_ev), 32'd1);
    step(); chk("hold_idle_outs", 32'(outs()), 32'd0);

    // Reset while open: outputs drop, pass during reset yields no event
    entry_req = 1;
    step(); chk("rst_pre_open", 32'(entry_open), 32'd1);
    rst = 1; entry_pass = 1;
    step(); chk("rst_outs", 32'(outs()), 32'd0);
    rst = 0; entry_req = 0; entry_pass = 0;
    c_ev = 0;
    for (int i = 0; i < 5; i++) begin
      step(); c_ev += int'(car_in);
    end
    chk("rst_no_carin", 32'(c_ev), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of cycles a gate stays open waiting for a car to pass.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of stable cycles a sensor needs before it is accepted (used only under REQ-026).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports entry_req, exit0_req and exit1_req, input, 1 bit each: a car is present at that lane's loop sensor (level).
REQ-006 The block SHALL have ports entry_pass, exit0_pass and exit1_pass, input, 1 bit each: the car has cleared that lane's barrier (level).
REQ-007 The block SHALL have ports full, floor0_free and floor1_free, input, 1 bit each: status from the occupancy manager.
REQ-008 The block SHALL have ports car_in, car_out0 and car_out1, output, 1 bit each: single-cycle event pulses to the occupancy manager.
REQ-009 The block SHALL have ports entry_open, exit0_open and exit1_open, output, 1 bit each: barrier-raise commands.
REQ-010 The block SHALL have port entry_denied, output, 1 bit: high while a car waits at entry and full=1.

Function
REQ-011 Each lane SHALL run its own state machine with states IDLE, OPEN and WAIT_CLR.
REQ-012 IDLE->OPEN transition rules:
- Entry lane: on entry_req=1 && full=0.
- Exit0 lane: on exit0_req=1 && floor0_free=0.
- Exit1 lane: on exit1_req=1 && floor1_free=0.
- Exit lanes leave only from a floor holding cars.
REQ-013 In OPEN the lane SHALL assert its open output and count cycles from 0.
REQ-014 OPEN->WAIT_CLR on a pass sensor SHALL occur when the lane's pass=1 while OPEN: queue exactly one event for that lane and drop the open output on the next cycle.
REQ-015 OPEN->WAIT_CLR on timeout SHALL occur when the count reaches TIMEOUT_CYCLES-1 without pass: queue no event.
REQ-016 WAIT_CLR->IDLE SHALL occur only when both req=0 and pass=0, so one car yields at most one event.
REQ-017 Queued events SHALL be held in a per-lane pending flag; the manager SHALL receive at most one pulse per cycle.
REQ-018 Pending flags SHALL drain in fixed priority: exit0 > exit1 > entry.
REQ-019 Event latency SHALL be:
- An unblocked pending flag produces its pulse in the cycle after the pass is sampled.
- Each lower-priority lane is delayed one cycle per higher-priority pulse.
REQ-020 A lane SHALL NOT leave WAIT_CLR while its own pending flag is set; therefore each lane has at most one outstanding event.
REQ-021 If full rises while the entry lane is OPEN, the gate SHALL stay open and the car completes normally; full is checked only at IDLE->OPEN.
REQ-022 entry_denied SHALL equal entry_req && full while the entry lane is IDLE, and 0 otherwise.
REQ-023 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES)+1 bits and SHALL saturate, never wrap.

Reset
REQ-024 rst=1 SHALL force every lane to IDLE, clear all pending flags and counters, and drive all outputs to 0, taking effect at the next clk edge, including mid-OPEN. Queued but unsent events are discarded.
REQ-025 The first transition after reset SHALL be evaluated on the first edge where rst=0.

Configuration
REQ-026 With macro PARKING_GATE_DEBOUNCE_EN defined:
- All six req/pass inputs pass through a debouncer.
- Each filtered value changes only after DEBOUNCE_CYCLES consecutive equal samples.
- Every response shifts by DEBOUNCE_CYCLES cycles.
REQ-027 Without PARKING_GATE_DEBOUNCE_EN, inputs SHALL be used directly as sampled, with no added latency.

Structure
REQ-028 Package parking_pkg SHALL hold the lane state enum (IDLE/OPEN/WAIT_CLR), the lane-index constants and the default TIMEOUT_CYCLES/DEBOUNCE_CYCLES values.
REQ-029 The lane state machine SHALL be sub-module gate_lane_fsm, instantiated three times; the arbiter and debouncers live in the top module.

Verification
REQ-030 Reset then entry_req=1, full=0, entry_pass at cycle 3 SHALL give:
- entry_open=1 from cycle 1 through cycle 3;
- a car_in pulse of exactly one cycle at cycle 4.
REQ-031 entry_req=1 with full=1 SHALL give entry_denied=1, entry_open=0 and no car_in for 20 cycles.
REQ-032 exit0_req=1 with floor0_free=0 and no pass SHALL give:
- exit0_open low after 16 cycles;
- no car_out0 pulse;
- re-entry to IDLE only after exit0_req=0.
REQ-033 exit0_pass, exit1_pass and entry_pass sampled in the same cycle SHALL give car_out0, car_out1 and car_in on three consecutive cycles, in that order.
REQ-034 entry_pass held high for 10 cycles SHALL give exactly one car_in pulse.
REQ-035 rst asserted while entry_open=1 SHALL give all outputs 0 at the next edge and no car_in afterwards.
